// File: rtl/pipe_pkg.sv
// Shared defaults and control-field layout for the pipeline stage registers
// placed between IF/ID, ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

    localparam int DATA_W_DEF = 96;
    localparam int CTRL_W_DEF = 20;
    localparam int CNT_W_DEF  = 16;

    // Bit positions of the decoded control word (LSB-first).
    localparam int CTRL_REG_WE    = 0;
    localparam int CTRL_JUMP      = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_MEM_WR    = 3;
    localparam int CTRL_MEM_RD    = 4;
    localparam int CTRL_FUN3_LSB  = 5;
    localparam int CTRL_FUN3_W    = 3;
    localparam int CTRL_ALU_OP_LSB = 8;
    localparam int CTRL_ALU_OP_W  = 4;
    localparam int CTRL_MUX_LSB   = 12;
    localparam int CTRL_MUX_W     = 8;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage register: upstream
// input side, downstream output side and the flush request.
interface pipe_stage_reg_if #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with a registered in_ready,
// bubble-zeroed control, flush and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic in_xfer;
    logic out_xfer;
    logic main_free;

    // in_ready comes only from skid_valid, so out_ready never reaches it.
    assign in_xfer   = bus.in_valid & ~skid_valid;
    assign out_xfer  = main_valid & bus.out_ready;
    assign main_free = ~main_valid | out_xfer;

    // NOTE: payload registers are reset too, so out_data reads 0 after reset
    // rather than X; the valid bits alone decide what is live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // in_ready was low, so no input competes with the skid entry.
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_xfer;
                if (in_xfer) begin
                    main_ctrl <= bus.in_ctrl;
                    main_data <= bus.in_data;
                end
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= bus.in_ctrl;
            skid_data  <= bus.in_data;
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
    assign bus.out_data  = main_data;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_valid & ~bus.out_ready),
        .clr   (clr_cnt),
        .cnt   (stall_cnt)
    );

endmodule
